// File: rtl/fir_transposed_param_pkg.sv
// Shared types and elaboration-time helpers for the transposed FIR filter.
// Optional build feature: FIR_ROUND_SAT_EN (round half-up with saturation on the output slice).
package fir_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } mode_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Full-precision accumulator width: product plus growth over all taps.
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + clog2(taps);
  endfunction

endpackage

// File: rtl/fir_transposed_param_tap.sv
// One transposed-form FIR tap: signed multiply, add of the downstream partial sum,
// and the partial-sum register. clr_i wipes filter state when coefficients are reloaded.
module fir_tap
  import fir_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int COEF_W = 9,
  parameter int ACC_W  = 21
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [COEF_W-1:0] c_i,
  input  logic signed [ACC_W-1:0]  a_next_i,
  output logic signed [ACC_W-1:0]  a_o
);
  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  a_q, a_d;

  assign prod = x_i * c_i;
  assign a_d  = ACC_W'(prod) + a_next_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
    end else if (clr_i) begin
      a_q <= '0;
    end else if (en_i) begin
      a_q <= a_d;
    end
  end

  assign a_o = a_q;

endmodule

// File: rtl/fir_transposed_param.sv
// Parametrised transposed-form FIR with serial coefficient loading and valid/ready input.
// Optional build feature: define FIR_ROUND_SAT_EN for round half-up and saturation on y_out.
module fir_transposed_param
  import fir_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int COEF_W = 9,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     coef_start,
  input  logic                     coef_valid,
  input  logic signed [COEF_W-1:0] coef_in,
  output logic                     coef_done,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] x_in,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  y_out
);
  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
  localparam int CNT_W = clog2(TAPS);

  mode_e                     state_q, state_d;
  logic [CNT_W-1:0]          cnt_q;
  logic signed [COEF_W-1:0]  c_q [TAPS];
  logic signed [DATA_W-1:0]  x_q;
  logic                      v1_q, v2_q, out_valid_q;
  logic signed [OUT_W-1:0]   y_q, y_d;
  logic signed [ACC_W-1:0]   a_w [TAPS+1];
  logic                      load_beat, accept;

  // coef_start takes priority over a coincident coefficient beat.
  assign load_beat = (state_q == LOAD) && coef_valid && !coef_start;
  assign in_ready  = (state_q == RUN) && !coef_start;
  assign accept    = in_valid && in_ready;
  assign coef_done = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    if (coef_start) begin
      state_d = LOAD;
    end else if (load_beat && (cnt_q == CNT_W'(TAPS - 1))) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      cnt_q       <= '0;
      x_q         <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      for (int k = 0; k < TAPS; k++) c_q[k] <= '0;
    end else begin
      state_q <= state_d;
      if (coef_start) begin
        cnt_q <= '0;
      end else if (load_beat) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (load_beat) begin
        for (int k = 0; k < TAPS - 1; k++) c_q[k] <= c_q[k+1];
        c_q[TAPS-1] <= coef_in;
      end
      if (coef_start) begin
        x_q         <= '0;
        v1_q        <= 1'b0;
        v2_q        <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        v1_q        <= accept;
        v2_q        <= v1_q;
        out_valid_q <= v2_q;
        if (accept) x_q <= x_in;
        if (v2_q) y_q <= y_d;
      end
    end
  end

  assign a_w[TAPS] = '0;

  for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
    fir_tap #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
    ) u_tap (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (coef_start),
      .en_i     (v1_q),
      .x_i      (x_q),
      .c_i      (c_q[gi]),
      .a_next_i (a_w[gi+1]),
      .a_o      (a_w[gi])
    );
  end

`ifdef FIR_ROUND_SAT_EN
  if (OUT_W == ACC_W) begin : g_pass
    assign y_d = a_w[0];
  end else begin : g_round
    localparam int RSH = ACC_W - OUT_W;
    localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(1) << (RSH - 1);
    logic [ACC_W:0] rnd;
    logic           unused_rnd_lsbs;
    assign rnd = {a_w[0][ACC_W-1], a_w[0]} + HALF;
    // Only a positive carry into the sign bit can overflow after adding the half LSB.
    assign y_d = (!rnd[ACC_W] && rnd[ACC_W-1]) ? {1'b0, {(OUT_W - 1){1'b1}}}
                                                : rnd[ACC_W-1 -: OUT_W];
    assign unused_rnd_lsbs = ^rnd[RSH-1:0];
  end
`else
  assign y_d = a_w[0][ACC_W-1 -: OUT_W];
  if (ACC_W > OUT_W) begin : g_trunc
    logic unused_lsbs;
    assign unused_lsbs = ^a_w[0][ACC_W-OUT_W-1:0];
  end
`endif

  assign out_valid = out_valid_q;
  assign y_out     = y_q;

endmodule

// File: tb/tb_fir_transposed_param.sv
// Scoreboard bench: a full-width instance (OUT_W=21) and a default instance (OUT_W=11) share stimulus.
module tb_fir_transposed_param;
  localparam int TAPS = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic coef_start = 1'b0, coef_valid = 1'b0, in_valid = 1'b0;
  logic signed [8:0] coef_in = '0, x_in = '0;

  logic coef_done_a, in_ready_a, out_valid_a;
  logic coef_done_b, in_ready_b, out_valid_b;
  logic signed [20:0] y_a;
  logic signed [10:0] y_b;

  fir_transposed_param #(.DATA_W(9), .COEF_W(9), .TAPS(TAPS), .OUT_W(21)) dut_a (
    .clk(clk), .reset(reset), .coef_start(coef_start), .coef_valid(coef_valid),
    .coef_in(coef_in), .coef_done(coef_done_a), .in_valid(in_valid), .x_in(x_in),
    .in_ready(in_ready_a), .out_valid(out_valid_a), .y_out(y_a));

  fir_transposed_param dut_b (
    .clk(clk), .reset(reset), .coef_start(coef_start), .coef_valid(coef_valid),
    .coef_in(coef_in), .coef_done(coef_done_b), .in_valid(in_valid), .x_in(x_in),
    .in_ready(in_ready_b), .out_valid(out_valid_b), .y_out(y_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int cyc;
    int ya;
    int yb;
  } exp_t;
  exp_t q[$];

  int  cm[TAPS];
  int  hist[TAPS];
  int  cset[TAPS];
  bit  run_m = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < TAPS; k++) hist[k] = 0;
  endtask

  // Drive one sample slot; a scoreboard entry is pushed only if the model says it is accepted.
  task automatic send(input int x, input bit v);
    exp_t e;
    int sum;
    @(posedge clk); #1;
    coef_start = 1'b0; coef_valid = 1'b0;
    in_valid = v; x_in = 9'(x);
    #1;
    check("in_ready_a", in_ready_a, run_m);
    check("in_ready_b", in_ready_b, run_m);
    if (v && run_m) begin
      for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = x;
      sum = 0;
      for (int k = 0; k < TAPS; k++) sum += cm[k] * hist[k];
      e.cyc = cyc + 3;
      e.ya  = sum;
      e.yb  = sum >>> 10;
      q.push_back(e);
      $display("accept x=%0d expect y=%0d / %0d at cycle %0d", x, e.ya, e.yb, e.cyc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(0, 1'b0);
  endtask

  // Start a reload and feed nb beats of cset; outputs still in flight are discarded by the DUT.
  task automatic load(input int nb);
    @(posedge clk); #1;
    in_valid = 1'b0; coef_valid = 1'b0; coef_start = 1'b1;
    while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
    run_m = 1'b0;
    clear_model();
    #1;
    check("in_ready_on_start", in_ready_a, 0);
    for (int i = 0; i < nb; i++) begin
      if (i == 4) begin
        @(posedge clk); #1;
        coef_start = 1'b0; coef_valid = 1'b0;
      end
      @(posedge clk); #1;
      coef_start = 1'b0; coef_valid = 1'b1; coef_in = 9'(cset[i]);
      #1;
      check("in_ready_load", in_ready_a, 0);
      check("coef_done_load", coef_done_a, 0);
    end
    @(posedge clk); #1;
    coef_valid = 1'b0;
    if (nb == TAPS) begin
      for (int k = 0; k < TAPS; k++) cm[k] = cset[k];
      run_m = 1'b1;
    end
    check("coef_done_a", coef_done_a, run_m);
    check("coef_done_b", coef_done_b, run_m);
    $display("load %0d beats, coef_done=%0d", nb, coef_done_a);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    coef_start = 1'b0; coef_valid = 1'b0; in_valid = 1'b0;
    q.delete();
    run_m = 1'b0;
    clear_model();
    for (int k = 0; k < TAPS; k++) cm[k] = 0;
    #1;
    check("rst_coef_done", coef_done_a, 0);
    check("rst_in_ready", in_ready_a, 0);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_y_a", y_a, 0);
    check("rst_y_b", y_b, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    $display("reset applied");
  endtask

  // Monitor: every output pulse must match the head of the scoreboard, on the predicted cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (out_valid_a) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", out_valid_a, 0);
        end else begin
          e = q.pop_front();
          check("latency", cyc, e.cyc);
          check("y_full", y_a, e.ya);
          check("valid_b", out_valid_b, 1);
          check("y_trunc", y_b, e.yb);
          $display("out y_full=%0d y_trunc=%0d cycle %0d", y_a, y_b, cyc);
        end
      end else if (out_valid_b) begin
        check("valid_b_spurious", out_valid_b, out_valid_a);
      end
    end
  end

  initial begin
    do_reset();

    // Impulse response reproduces the coefficient set.
    for (int k = 0; k < TAPS; k++) cset[k] = k + 1;
    load(TAPS);
    send(1, 1'b1);
    for (int i = 0; i < 9; i++) send(0, 1'b1);
    idle(4);

    // Extremes: largest positive and largest negative products, no wrap.
    for (int k = 0; k < TAPS; k++) cset[k] = 255;
    load(TAPS);
    for (int i = 0; i < 10; i++) send(255, 1'b1);
    idle(4);
    for (int k = 0; k < TAPS; k++) cset[k] = -256;
    load(TAPS);
    for (int i = 0; i < 10; i++) send(-256, 1'b1);
    idle(4);

    // Stall: gaps in in_valid must not disturb the filter history.
    for (int k = 0; k < TAPS; k++) cset[k] = (k % 2 == 0) ? (k + 3) : -(k + 1);
    load(TAPS);
    for (int i = 0; i < 16; i++) send(i * 7 - 40, (i % 4 == 0) || (i % 4 == 3));
    idle(4);

    // Reload mid-stream: history is flushed, in-flight outputs are dropped.
    for (int k = 0; k < TAPS; k++) cset[k] = k + 1;
    load(TAPS);
    for (int i = 0; i < 5; i++) send(10 + i, 1'b1);
    for (int k = 0; k < TAPS; k++) cset[k] = (k == 0) ? 2 : 0;
    load(TAPS);
    send(7, 1'b1);
    send(-3, 1'b1);
    idle(4);

    // Values around the output LSB boundary: 511 and 512.
    for (int k = 0; k < TAPS; k++) cset[k] = (k == 0) ? 2 : ((k == 1) ? 1 : 0);
    load(TAPS);
    send(1, 1'b1);
    send(255, 1'b1);
    send(2, 1'b1);
    send(255, 1'b1);
    idle(4);

    // Reset during a partial load: nothing is accepted until a full reload.
    for (int k = 0; k < TAPS; k++) cset[k] = k + 1;
    load(3);
    do_reset();
    send(5, 1'b1);
    send(6, 1'b1);
    load(TAPS);
    send(1, 1'b1);
    send(0, 1'b1);
    idle(6);

    check("pending_outputs", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_transposed_param.md
Name: fir_transposed_param

Overview:
- Parametrised transposed-form FIR filter with run-time serial coefficient loading, a valid/ready sample handshake and a filter-state flush on reload.
- Generalises the team's fixed 4-tap filter to arbitrary tap count and data/coefficient/output widths.
- Sits between the ADC sample front-end and the decimation/output stage; one sample is accepted per enabled cycle.

Parameters:
- DATA_W, 9, signed input sample width.
- COEF_W, 9, signed coefficient width.
- TAPS, 8, filter length; must be at least 2.
- OUT_W, 11, output width; must be at most ACC_W.
- ACC_W, derived localparam = DATA_W+COEF_W+clog2(TAPS); accumulator width, 21 at the defaults.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- coef_start  in  1  single-cycle pulse; begins a coefficient reload.
- coef_valid  in  1  coef_in holds a valid coefficient this cycle.
- coef_in  in  COEF_W  signed coefficient data.
- coef_done  out  1  high while a complete coefficient set is loaded (RUN state).
- in_valid  in  1  x_in holds a valid sample.
- x_in  in  DATA_W  signed sample.
- in_ready  out  1  block accepts a sample this cycle.
- out_valid  out  1  y_out holds a valid result.
- y_out  out  OUT_W  signed filtered output.

Behaviour:
- Reset: mode state = EMPTY; coefficients, x register, accumulators a[0..TAPS-1], load counter, out_valid, y_out and coef_done all cleared to 0.
- Mode FSM has three states: EMPTY, LOAD, RUN.
  - EMPTY/RUN/LOAD to LOAD on coef_start. Entering LOAD clears the counter, x, a[], and the out_valid pipeline. A coef_start during LOAD restarts the count.
  - LOAD: each coef_valid beat shifts the array: c[TAPS-1] <= coef_in, c[k] <= c[k+1]. The first beat therefore ends in c[0].
  - LOAD to RUN after the TAPS-th beat. coef_done goes high on the same edge.
  - coef_valid outside LOAD is ignored.
- in_ready = (state==RUN) && !coef_start, combinational. A sample arriving together with coef_start is not accepted.
- Accept = in_valid && in_ready.
- Pipeline is clock-enabled by accept; it holds state when no sample is accepted.
  - Edge n, accepted sample: x <= x_in, stage-1 valid <= 1.
  - Next edge with stage-1 valid: a[TAPS-1] <= p[TAPS-1] and a[k] <= p[k] + a[k+1], where p[k] = x*c[k] at full DATA_W+COEF_W width, sign-extended to ACC_W. y_out and out_valid register from a[0].
  - Latency: out_valid asserts 2 edges after the accepting edge. Accepted samples map 1:1 to out_valid pulses, in order.
  - y[n] = sum over k of c[k]*x[n-k].
- Output slice by default: y_out = a[0][ACC_W-1 -: OUT_W], truncation toward minus infinity. No overflow is possible in the accumulator.
- Reset asserted mid-operation clears everything immediately, including loaded coefficients. The block returns to EMPTY and needs a full reload.

Optional Feature:
- Macro FIR_ROUND_SAT_EN.
- Defined: round half-up by adding 2^(ACC_W-OUT_W-1) before the slice. If the rounded value exceeds the OUT_W signed maximum, y_out saturates to that maximum. When OUT_W==ACC_W the slice is passed unchanged.
- Undefined: plain truncation as above. No extra logic is generated.

Decomposition:
- Package fir_pkg contains the clog2 function, the state enum (EMPTY, LOAD, RUN) and the ACC_W computation helper.
- One natural sub-module, fir_tap: multiplier plus adder plus accumulator register, with enable. It is instantiated TAPS times by a generate loop. The last tap ties its a[k+1] input to 0.

Test Plan:
- Impulse (OUT_W=21, TAPS=8): load coefficients 1..8, feed x = 1,0,0,...; y_out = 1,2,3,...,8, then 0, with out_valid 2 edges after each accept.
- Extremes (OUT_W=21): all coefficients 255 and x = 255 steady give steady y = 520200. All coefficients -256 and x = -256 give 524288. No wrap in either case.
- Stall: in_valid toggles 1,0,0,1 with ramp data; outputs match the gap-free golden sequence, and the number of out_valid pulses equals the number of accepts.
- Reload: coef_start mid-stream, then load coefficients 2,0,...; in_ready is low during LOAD; the first output after reload equals 2*x with no history from before the reload.
- Rounding (defaults, macro on): a[0] = 511 gives 0; a[0] = 512 gives 1; a[0] = 2^20-1 saturates to 1023. With the macro off, all three give 0, 0 and 1023.
- Reset mid-LOAD after 3 beats: all outputs are 0, coef_done = 0 and in_ready = 0 until a full 8-beat reload completes.
